// File: rtl/nand_master_ctrl.sv
// ONFI-style 8-bit NAND master: turns single-cycle host commands into NAND bus
// cycles (reset, READ ID, PAGE READ) and gives byte-wise access to its buffers.
module nand_master_ctrl #(
    parameter int PAGE_BYTES = 2048,
    parameter int T_WL       = 4,
    parameter int T_WH       = 4,
    parameter int T_RL       = 6,
    parameter int T_RH       = 7,
    parameter int T_WB       = 40
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic        activate,
    input  logic [5:0]  cmd_in,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        nand_cle,
    output logic        nand_ale,
    output logic        nand_nwe,
    output logic        nand_nre,
    output logic        nand_nce,
    output logic        nand_nwp,
    input  logic        nand_rnb,
    inout  wire  [15:0] nand_data
);

    localparam int IW = $clog2(PAGE_BYTES);

    localparam logic [5:0] C_M_RESET          = 6'h01;
    localparam logic [5:0] C_M_NAND_RESET     = 6'h04;
    localparam logic [5:0] C_M_NAND_READ_ID   = 6'h06;
    localparam logic [5:0] C_M_NAND_READ      = 6'h09;
    localparam logic [5:0] C_MI_GET_STATUS    = 6'h0D;
    localparam logic [5:0] C_MI_CHIP_ENABLE   = 6'h0E;
    localparam logic [5:0] C_MI_CHIP_DISABLE  = 6'h0F;
    localparam logic [5:0] C_MI_WRITE_PROTECT = 6'h10;
    localparam logic [5:0] C_MI_WRITE_ENABLE  = 6'h11;
    localparam logic [5:0] C_MI_RESET_INDEX   = 6'h12;
    localparam logic [5:0] C_MI_GET_ID_BYTE   = 6'h13;
    localparam logic [5:0] C_MI_GET_PAGE_BYTE = 6'h15;
    localparam logic [5:0] C_MI_SET_ADDR_BYTE = 6'h18;

    localparam logic [7:0] C_WL_END = 8'(1 + T_WL);
    localparam logic [7:0] C_WH_END = 8'(1 + T_WL + T_WH);
    localparam logic [7:0] C_RL     = 8'(T_RL);
    localparam logic [7:0] C_R_END  = 8'(T_RL + T_RH - 1);
    localparam logic [7:0] C_WB_END = 8'(T_WB - 1);

    localparam logic [IW-1:0] C_PAGE_LAST = IW'(PAGE_BYTES - 1);
    localparam logic [IW-1:0] C_ID_LAST   = IW'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_WR,
        S_ADDR_WR,
        S_WAIT_WB,
        S_WAIT_RNB,
        S_DATA_RD,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [5:0]      r_cmd;
    logic [7:0]      r_arg;
    logic [7:0]      r_cnt;
    logic [2:0]      r_acnt;
    logic            r_second;
    logic [IW-1:0]   r_index;
    logic [7:0]      r_id   [0:7];
    logic [7:0]      r_addr [0:4];
    logic [7:0]      r_page [0:PAGE_BYTES-1];
    logic [7:0]      r_data_out;
    logic            r_busy;
    logic            r_cle;
    logic            r_ale;
    logic            r_nwe;
    logic            r_nre;
    logic            r_nce;
    logic            r_nwp;
    logic            r_drive;
    logic [7:0]      r_dout;

    logic            w_nand_cmd;
    logic            w_soft_rst;
    logic            w_page_we;
    logic [IW-1:0]   w_last;
    logic [7:0]      w_wr_byte;
    logic            w_unused_hi;

    assign w_nand_cmd = (cmd_in == C_M_NAND_RESET) || (cmd_in == C_M_NAND_READ_ID) ||
                        (cmd_in == C_M_NAND_READ);
    assign w_soft_rst = (enable == 1'b0) && (r_state == S_DONE) && (r_cmd == C_M_RESET);
    assign w_page_we  = (nreset == 1'b0) && (enable == 1'b0) && (r_state == S_DATA_RD) &&
                        (r_cnt == C_RL) && (r_cmd == C_M_NAND_READ);
    assign w_last     = (r_cmd == C_M_NAND_READ_ID) ? C_ID_LAST : C_PAGE_LAST;
    assign w_unused_hi = ^nand_data[15:8];

    // Byte placed on the bus for the current command or address write cycle
    always_comb begin
        w_wr_byte = 8'h00;
        if (r_state == S_ADDR_WR) begin
            if (r_cmd == C_M_NAND_READ_ID) begin
                w_wr_byte = r_arg;
            end else begin
                w_wr_byte = r_addr[r_acnt];
            end
        end else begin
            case (r_cmd)
                C_M_NAND_RESET:   w_wr_byte = 8'hFF;
                C_M_NAND_READ_ID: w_wr_byte = 8'h90;
                C_M_NAND_READ:    w_wr_byte = r_second ? 8'h30 : 8'h00;
                default:          w_wr_byte = 8'h00;
            endcase
        end
    end

    // Page buffer capture; kept free of reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (w_page_we) begin
            r_page[r_index] <= nand_data[7:0];
        end
    end

    // Command FSM, host-visible registers and NAND pin drivers
    always_ff @(posedge clk) begin
        if (nreset || w_soft_rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= 6'h00;
            r_arg      <= 8'h00;
            r_cnt      <= 8'h00;
            r_acnt     <= 3'd0;
            r_second   <= 1'b0;
            r_index    <= '0;
            r_data_out <= 8'h00;
            r_busy     <= 1'b0;
            r_cle      <= 1'b0;
            r_ale      <= 1'b0;
            r_nwe      <= 1'b1;
            r_nre      <= 1'b1;
            r_nce      <= 1'b1;
            r_nwp      <= 1'b0;
            r_drive    <= 1'b0;
            r_dout     <= 8'h00;
            for (int i = 0; i < 8; i++) r_id[i] <= 8'h00;
            for (int i = 0; i < 5; i++) r_addr[i] <= 8'h00;
        end else if (enable == 1'b0) begin
            case (r_state)
                S_IDLE: begin
                    if (activate) begin
                        r_cmd    <= cmd_in;
                        r_arg    <= data_in;
                        r_busy   <= 1'b1;
                        r_cnt    <= 8'h00;
                        r_acnt   <= 3'd0;
                        r_second <= 1'b0;
                        r_state  <= w_nand_cmd ? S_CMD_WR : S_DONE;
                    end
                end
                // Write cycle: one setup clock, T_WL low, T_WH high, then release
                S_CMD_WR, S_ADDR_WR: begin
                    if (r_cnt == 8'd0) begin
                        r_cle   <= (r_state == S_CMD_WR);
                        r_ale   <= (r_state == S_ADDR_WR);
                        r_dout  <= w_wr_byte;
                        r_drive <= 1'b1;
                        r_cnt   <= r_cnt + 8'd1;
                    end else if (r_cnt == 8'd1) begin
                        r_nwe <= 1'b0;
                        r_cnt <= r_cnt + 8'd1;
                    end else if (r_cnt == C_WL_END) begin
                        r_nwe <= 1'b1;
                        r_cnt <= r_cnt + 8'd1;
                    end else if (r_cnt == C_WH_END) begin
                        r_cle   <= 1'b0;
                        r_ale   <= 1'b0;
                        r_drive <= 1'b0;
                        r_cnt   <= 8'h00;
                        if (r_state == S_CMD_WR) begin
                            if ((r_cmd == C_M_NAND_RESET) || r_second) begin
                                r_state <= S_WAIT_WB;
                            end else begin
                                r_state <= S_ADDR_WR;
                            end
                        end else if ((r_cmd == C_M_NAND_READ) && (r_acnt != 3'd4)) begin
                            r_acnt <= r_acnt + 3'd1;
                        end else if (r_cmd == C_M_NAND_READ) begin
                            r_second <= 1'b1;
                            r_state  <= S_CMD_WR;
                        end else begin
                            r_state <= S_WAIT_WB;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WAIT_WB: begin
                    if (r_cnt == C_WB_END) begin
                        r_cnt <= 8'h00;
                        if (r_cmd == C_M_NAND_READ_ID) begin
                            r_index <= '0;
                            r_state <= S_DATA_RD;
                        end else begin
                            r_state <= S_WAIT_RNB;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WAIT_RNB: begin
                    if (nand_rnb) begin
                        r_cnt   <= 8'h00;
                        r_index <= '0;
                        r_state <= (r_cmd == C_M_NAND_READ) ? S_DATA_RD : S_DONE;
                    end
                end
                // Read cycle: data is captured on the last low clock of nre
                S_DATA_RD: begin
                    if (r_cnt == 8'd0) begin
                        r_nre <= 1'b0;
                        r_cnt <= r_cnt + 8'd1;
                    end else if (r_cnt == C_RL) begin
                        r_nre <= 1'b1;
                        if (r_cmd == C_M_NAND_READ_ID) begin
                            r_id[r_index[2:0]] <= nand_data[7:0];
                        end
                        r_cnt <= r_cnt + 8'd1;
                    end else if (r_cnt == C_R_END) begin
                        r_cnt <= 8'h00;
                        if (r_index == w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    case (r_cmd)
                        // Bit 2 reports write-enabled (nwp high), bit 1 chip selected
                        C_MI_GET_STATUS:    r_data_out <= {4'b0000, nand_rnb, r_nwp, ~r_nce, 1'b0};
                        C_MI_CHIP_ENABLE:   r_nce <= 1'b0;
                        C_MI_CHIP_DISABLE:  r_nce <= 1'b1;
                        C_MI_WRITE_PROTECT: r_nwp <= 1'b0;
                        C_MI_WRITE_ENABLE:  r_nwp <= 1'b1;
                        C_MI_RESET_INDEX:   r_index <= '0;
                        C_MI_GET_ID_BYTE: begin
                            r_data_out <= r_id[r_index[2:0]];
                            r_index    <= r_index + 1'b1;
                        end
                        C_MI_GET_PAGE_BYTE: begin
                            r_data_out <= r_page[r_index];
                            r_index    <= r_index + 1'b1;
                        end
                        C_MI_SET_ADDR_BYTE: begin
                            if (r_index[2:0] <= 3'd4) begin
                                r_addr[r_index[2:0]] <= r_arg;
                            end
                            r_index <= r_index + 1'b1;
                        end
                        C_M_NAND_READ_ID: begin
                            r_index <= '0;
                            r_id[5] <= 8'h00;
                            r_id[6] <= 8'h00;
                            r_id[7] <= 8'h00;
                        end
                        C_M_NAND_READ: r_index <= '0;
                        default: ;
                    endcase
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign busy      = r_busy;
    assign nand_cle  = r_cle;
    assign nand_ale  = r_ale;
    assign nand_nwe  = r_nwe;
    assign nand_nre  = r_nre;
    assign nand_nce  = r_nce;
    assign nand_nwp  = r_nwp;
    assign nand_data = r_drive ? {8'hzz, r_dout} : 16'hzzzz;

endmodule

// File: tb/tb_nand_master_ctrl.sv
// Self-checking bench for nand_master_ctrl: table-driven host commands plus a
// NAND device model, with scoreboards for host results and bus write cycles.
module tb_nand_master_ctrl;

    localparam int T_WL = 4;
    localparam int T_RL = 6;
    localparam int PAGE = 2048;

    localparam logic [5:0] C_M_RESET   = 6'h01;
    localparam logic [5:0] C_NRESET    = 6'h04;
    localparam logic [5:0] C_READ_ID   = 6'h06;
    localparam logic [5:0] C_READ      = 6'h09;
    localparam logic [5:0] C_STATUS    = 6'h0D;
    localparam logic [5:0] C_CE        = 6'h0E;
    localparam logic [5:0] C_CD        = 6'h0F;
    localparam logic [5:0] C_WP        = 6'h10;
    localparam logic [5:0] C_WE        = 6'h11;
    localparam logic [5:0] C_RST_IDX   = 6'h12;
    localparam logic [5:0] C_GET_ID    = 6'h13;
    localparam logic [5:0] C_GET_PAGE  = 6'h15;
    localparam logic [5:0] C_SET_ADDR  = 6'h18;

    typedef struct {
        logic [5:0] cmd;
        logic [7:0] arg;
        logic       rnb;
        logic       chk;
        logic [7:0] exp;
        logic       nce;
        logic       nwp;
    } vec_t;

    logic        clk = 1'b0;
    logic        nreset, enable, activate, nand_rnb;
    logic [5:0]  cmd_in;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        busy, nand_cle, nand_ale, nand_nwe, nand_nre, nand_nce, nand_nwp;
    wire  [15:0] nand_bus;

    int          n_vec = 0;
    int          n_err = 0;
    logic        in_abort = 1'b1;
    logic [7:0]  exp_q [$];
    logic [9:0]  exp_wr [$];

    logic [7:0]  id_bytes [0:4];
    logic        dev_mode;
    int          rd_count = 0;
    int          rd_base;
    int          k_dev;
    logic [7:0]  dev_byte;

    always #5 clk = ~clk;

    nand_master_ctrl dut (
        .clk       (clk),
        .nreset    (nreset),
        .enable    (enable),
        .activate  (activate),
        .cmd_in    (cmd_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .nand_cle  (nand_cle),
        .nand_ale  (nand_ale),
        .nand_nwe  (nand_nwe),
        .nand_nre  (nand_nre),
        .nand_nce  (nand_nce),
        .nand_nwp  (nand_nwp),
        .nand_rnb  (nand_rnb),
        .nand_data (nand_bus)
    );

    function automatic logic [7:0] page_byte(input int k);
        return 8'((k * 13 + 7) % 256);
    endfunction

    // Device model: drives the next byte while nre is low
    always_comb begin
        k_dev = rd_count - rd_base;
        if (dev_mode) begin
            dev_byte = page_byte(k_dev);
        end else if (k_dev >= 0 && k_dev < 5) begin
            dev_byte = id_bytes[k_dev[2:0]];
        end else begin
            dev_byte = 8'hEE;
        end
    end

    assign nand_bus[7:0] = (nand_nre == 1'b0) ? dev_byte : 8'hzz;

    always @(posedge nand_nre) rd_count <= rd_count + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: strobe widths, write setup, and write-cycle scoreboard
    logic nwe_prev = 1'b1, nre_prev = 1'b1, strobe_prev = 1'b0;
    int   nwe_low = 0, nre_low = 0;
    always @(negedge clk) begin
        if (!in_abort && nwe_prev && !nand_nwe)
            check("wr_setup", 32'(strobe_prev), 32'(1'b1));
        if (!in_abort && !nwe_prev && nand_nwe) begin
            check("nwe_low_clks", 32'(nwe_low), 32'(T_WL));
            if (exp_wr.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_unexpected: got cle/ale/data 0x%0h, expected no write",
                         {nand_cle, nand_ale, nand_bus[7:0]});
            end else begin
                check("wr_cycle", 32'({nand_cle, nand_ale, nand_bus[7:0]}), 32'(exp_wr.pop_front()));
            end
        end
        if (!in_abort && !nre_prev && nand_nre)
            check("nre_low_clks", 32'(nre_low), 32'(T_RL));
        nwe_low     <= nand_nwe ? 0 : nwe_low + 1;
        nre_low     <= nand_nre ? 0 : nre_low + 1;
        nwe_prev    <= nand_nwe;
        nre_prev    <= nand_nre;
        strobe_prev <= nand_cle | nand_ale;
    end

    task automatic start_cmd(input logic [5:0] c, input logic [7:0] a);
        @(negedge clk);
        cmd_in   = c;
        data_in  = a;
        activate = 1'b1;
        @(negedge clk);
        activate = 1'b0;
    endtask

    task automatic mi(input logic [5:0] c, input logic [7:0] a, input logic chk, input logic [7:0] exp);
        if (chk) exp_q.push_back(exp);
        start_cmd(c, a);
        check("mi_busy_set", 32'(busy), 32'(1'b1));
        @(negedge clk);
        check("mi_busy_clr", 32'(busy), 32'(1'b0));
        if (chk) check("mi_data_out", 32'(data_out), 32'(exp_q.pop_front()));
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'(1'b0));
    endtask

    task automatic push_read_writes();
        exp_wr.push_back({2'b10, 8'h00});
        exp_wr.push_back({2'b01, 8'hA1});
        exp_wr.push_back({2'b01, 8'hB2});
        exp_wr.push_back({2'b01, 8'h05});
        exp_wr.push_back({2'b01, 8'hC3});
        exp_wr.push_back({2'b01, 8'hD4});
        exp_wr.push_back({2'b10, 8'h30});
    endtask

    initial begin
        vec_t       vt [18];
        logic [7:0] exp_id [0:7];
        logic [7:0] addr_b [0:4];
        int         n;

        vt[0]  = '{C_STATUS, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[1]  = '{C_STATUS, 8'h00, 1'b1, 1'b1, 8'h08, 1'b1, 1'b0};
        vt[2]  = '{C_CE,     8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[3]  = '{C_WE,     8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[4]  = '{C_STATUS, 8'h00, 1'b1, 1'b1, 8'h0E, 1'b0, 1'b1};
        vt[5]  = '{C_STATUS, 8'h00, 1'b0, 1'b1, 8'h06, 1'b0, 1'b1};
        vt[6]  = '{C_WP,     8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[7]  = '{C_STATUS, 8'h00, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0};
        vt[8]  = '{C_CD,     8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[9]  = '{C_STATUS, 8'h00, 1'b1, 1'b1, 8'h08, 1'b1, 1'b0};
        vt[10] = '{6'h3F,    8'hFF, 1'b1, 1'b1, 8'h08, 1'b1, 1'b0};
        vt[11] = '{C_CE,     8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[12] = '{C_WE,     8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[13] = '{C_STATUS, 8'h00, 1'b1, 1'b1, 8'h0E, 1'b0, 1'b1};
        vt[14] = '{C_M_RESET,8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[15] = '{C_CE,     8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[16] = '{C_WE,     8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[17] = '{C_STATUS, 8'h00, 1'b1, 1'b1, 8'h0E, 1'b0, 1'b1};

        id_bytes[0] = 8'h2C; id_bytes[1] = 8'hE5; id_bytes[2] = 8'hFF;
        id_bytes[3] = 8'h03; id_bytes[4] = 8'h86;
        for (int i = 0; i < 8; i++) exp_id[i] = (i < 5) ? id_bytes[i] : 8'h00;
        addr_b[0] = 8'hA1; addr_b[1] = 8'hB2; addr_b[2] = 8'h05;
        addr_b[3] = 8'hC3; addr_b[4] = 8'hD4;

        nreset = 1'b1; enable = 1'b0; activate = 1'b0; cmd_in = 6'h00;
        data_in = 8'h00; nand_rnb = 1'b0; dev_mode = 1'b0; rd_base = 0;
        repeat (3) @(negedge clk);
        check("reset_pins", 32'({nand_cle, nand_ale, nand_nwe, nand_nre, nand_nce, nand_nwp, busy, data_out}),
              32'({7'b0011100, 8'h00}));
        nreset = 1'b0;
        @(negedge clk);
        in_abort = 1'b0;

        for (int i = 0; i < 18; i++) begin
            nand_rnb = vt[i].rnb;
            mi(vt[i].cmd, vt[i].arg, vt[i].chk, vt[i].exp);
            check($sformatf("vec%0d_pins", i), 32'({nand_nce, nand_nwp}), 32'({vt[i].nce, vt[i].nwp}));
        end

        // NAND reset: busy held while rnb is low, clears two clocks after it rises
        nand_rnb = 1'b0;
        exp_wr.push_back({2'b10, 8'hFF});
        start_cmd(C_NRESET, 8'h00);
        repeat (120) @(negedge clk);
        check("nrst_busy_hold", 32'(busy), 32'(1'b1));
        check("nrst_wr_done", 32'(exp_wr.size()), 32'(0));
        nand_rnb = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("nrst_clear_lat", 32'(n), 32'(2));
        check("nrst_nce_kept", 32'(nand_nce), 32'(1'b0));

        // READ ID
        dev_mode = 1'b0;
        rd_base  = rd_count;
        exp_wr.push_back({2'b10, 8'h90});
        exp_wr.push_back({2'b01, 8'h00});
        start_cmd(C_READ_ID, 8'h00);
        wait_idle(600, "readid_timeout");
        check("readid_nbytes", 32'(rd_count - rd_base), 32'(5));
        for (int i = 0; i < 8; i++) mi(C_GET_ID, 8'h00, 1'b1, exp_id[i]);

        // Page read
        mi(C_RST_IDX, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) mi(C_SET_ADDR, addr_b[i], 1'b0, 8'h00);
        dev_mode = 1'b1;
        rd_base  = rd_count;
        push_read_writes();
        start_cmd(C_READ, 8'h00);
        wait_idle(30000, "read_timeout");
        check("read_nbytes", 32'(rd_count - rd_base), 32'(PAGE));
        check("read_wr_done", 32'(exp_wr.size()), 32'(0));
        mi(C_RST_IDX, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < PAGE; i++) mi(C_GET_PAGE, 8'h00, 1'b1, page_byte(i));
        mi(C_GET_PAGE, 8'h00, 1'b1, page_byte(0));

        // Activate while busy is ignored; nreset mid-read aborts
        rd_base = rd_count;
        push_read_writes();
        start_cmd(C_READ, 8'h00);
        repeat (300) @(negedge clk);
        start_cmd(C_CD, 8'h00);
        repeat (3) @(negedge clk);
        check("busy_ignore", 32'({busy, nand_nce}), 32'({1'b1, 1'b0}));
        check("abort_wr_done", 32'(exp_wr.size()), 32'(0));
        in_abort = 1'b1;
        nreset = 1'b1;
        @(negedge clk);
        check("abort_pins", 32'({nand_cle, nand_ale, nand_nwe, nand_nre, nand_nce, nand_nwp, busy, data_out}),
              32'({7'b0011100, 8'h00}));
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        in_abort = 1'b0;

        // enable=1 freezes the FSM
        enable = 1'b1;
        start_cmd(C_CE, 8'h00);
        repeat (2) @(negedge clk);
        check("freeze", 32'({busy, nand_nce}), 32'({1'b0, 1'b1}));
        enable = 1'b0;
        @(negedge clk);
        mi(C_GET_ID, 8'h00, 1'b1, 8'h00);
        mi(C_STATUS, 8'h00, 1'b1, 8'h08);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
